pipe_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 6-stage pipeline (PC, IF, ID, EX, MEM, WB).
//  - Merges per-stage stall requests into the stall[5:0] vector used by every pipeline register.
//  - Accepts taken-branch redirects from EX and flushes the wrong-path instructions.
//  - Delays the PC redirect while an IF memory fetch is still in flight.
//  - Watches for a pipeline that stays stalled indefinitely.

---
 rtl/pipe_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl : stall/flush sequencer for the 6-stage pipeline
//             (PC, IF, ID, EX, MEM, WB).
//  - Merges per-stage stall requests into one hold vector (1 = hold stage).
//  - Accepts taken-branch redirects from EX and flushes wrong-path work.
//  - If a fetch is still in flight when a redirect arrives, the new PC is
//    parked and IF is told to drain until memory goes idle.
//  - Sticky watchdog flag for a pipeline stalled too long.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the stall-cycle and
// accepted-redirect performance counters; otherwise both ports read zero.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int ADDR_W        = 32,
   parameter int STALL_TIMEOUT = 1024,
   parameter int WDOG_W        = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_if,
   input  logic              stallreq_id,
   input  logic              stallreq_ex,
   input  logic              stallreq_mem,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic [5:0]        stall,
   output logic              flush_o,
   output logic              new_pc_valid_o,
   output logic [ADDR_W-1:0] new_pc_o,
   output logic              drain_o,
   output logic              hang_o,
   output logic [31:0]       stall_cycles_o,
   output logic [31:0]       flush_cnt_o
);

   typedef enum logic [0:0] {
      S_RUN   = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(STALL_TIMEOUT);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              hang_q, hang_d;

   logic              accept_s;
   logic [5:0]        stall_s;
   logic              flush_s;
   logic              npc_valid_s;
   logic [ADDR_W-1:0] npc_s;
   logic              drain_s;
   logic              stall_nz_s;

   // Redirect acceptance: only in RUN and only when EX/MEM are not frozen
   // (a frozen EX keeps the flag high, so it is taken once the stall clears).
   always_comb begin
      accept_s = (state_q == S_RUN) & branch_flag_i & ~stallreq_ex & ~stallreq_mem;
   end

   // Stall vector priority: MEM over EX over redirect over drain over load-use
   // over fetch; a flush beats a load-use stall since the ID op is wrong-path.
   always_comb begin
      stall_s = 6'b000000;
      if (stallreq_mem) begin
         stall_s = 6'b011111;
      end else if (stallreq_ex) begin
         stall_s = 6'b001111;
      end else if (accept_s && stallreq_if) begin
         stall_s = 6'b000011;
      end else if (accept_s) begin
         stall_s = 6'b000000;
      end else if (state_q == S_DRAIN) begin
         stall_s = 6'b000011;
      end else if (stallreq_id) begin
         stall_s = 6'b000111;
      end else if (stallreq_if) begin
         stall_s = 6'b000011;
      end else begin
         stall_s = 6'b000000;
      end
      stall_nz_s = |stall_s;
   end

   // Redirect FSM next-state and flush/redirect/drain decode.
   always_comb begin
      state_d     = state_q;
      pend_pc_d   = pend_pc_q;
      flush_s     = 1'b0;
      npc_valid_s = 1'b0;
      npc_s       = '0;
      drain_s     = 1'b0;
      case (state_q)
         S_RUN: begin
            if (accept_s) begin
               flush_s = 1'b1;
               if (stallreq_if) begin
                  // Fetch still in flight: park the target, discard the fetch.
                  drain_s   = 1'b1;
                  pend_pc_d = branch_target_i;
                  state_d   = S_DRAIN;
               end else begin
                  npc_valid_s = 1'b1;
                  npc_s       = branch_target_i;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            // Only bubbles sit downstream, so branch/load-use inputs are moot.
            drain_s = 1'b1;
            if (!stallreq_if) begin
               npc_valid_s = 1'b1;
               npc_s       = pend_pc_q;
               state_d     = S_RUN;
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   // Watchdog: count consecutive stalled cycles, saturate, latch hang flag.
   always_comb begin
      if (!stall_nz_s) begin
         wdog_d = '0;
      end else if (wdog_q == WDOG_LIMIT) begin
         wdog_d = wdog_q;
      end else begin
         wdog_d = wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
      end
      hang_d = hang_q | (wdog_d == WDOG_LIMIT);
   end

   // State, parked redirect target and watchdog registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_RUN;
         pend_pc_q <= '0;
         wdog_q    <= '0;
         hang_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
         wdog_q    <= wdog_d;
         hang_q    <= hang_d;
      end
   end

   // Outputs: combinational decode, forced quiet while reset is asserted.
   always_comb begin
      if (!rst) begin
         stall          = 6'b000000;
         flush_o        = 1'b0;
         new_pc_valid_o = 1'b0;
         new_pc_o       = '0;
         drain_o        = 1'b0;
      end else begin
         stall          = stall_s;
         flush_o        = flush_s;
         new_pc_valid_o = npc_valid_s;
         new_pc_o       = npc_s;
         drain_o        = drain_s;
      end
      hang_o = hang_q;
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Performance counter increments (free-running, wrap mod 2^32).
   always_comb begin
      if (stall_nz_s) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end else begin
         stall_cycles_d = stall_cycles_q;
      end
      if (accept_s) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_q <= 32'd0;
         flush_cnt_q    <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_cnt_q    <= flush_cnt_d;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_cnt_o    = flush_cnt_q;
`else
   assign stall_cycles_o = 32'h0;
   assign flush_cnt_o    = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl : directed self-checking bench for pipe_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 2 units later, well before the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_ctrl;

   localparam int ADDR_W = 32;

   logic              clk;
   logic              rst;
   logic              stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
   logic              branch_flag_i;
   logic [ADDR_W-1:0] branch_target_i;
   logic [5:0]        stall;
   logic              flush_o, new_pc_valid_o, drain_o, hang_o;
   logic [ADDR_W-1:0] new_pc_o;
   logic [31:0]       stall_cycles_o, flush_cnt_o;

   int n_checks = 0;
   int n_errors = 0;

   pipe_ctrl #(
      .ADDR_W(32), .STALL_TIMEOUT(8), .WDOG_W(4)
   ) dut (
      .clk(clk), .rst(rst),
      .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
      .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
      .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
      .stall(stall), .flush_o(flush_o), .new_pc_valid_o(new_pc_valid_o),
      .new_pc_o(new_pc_o), .drain_o(drain_o), .hang_o(hang_o),
      .stall_cycles_o(stall_cycles_o), .flush_cnt_o(flush_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic f_if, input logic f_id, input logic f_ex,
                        input logic f_mem, input logic bf, input logic [31:0] tgt);
      stallreq_if     = f_if;
      stallreq_id     = f_id;
      stallreq_ex     = f_ex;
      stallreq_mem    = f_mem;
      branch_flag_i   = bf;
      branch_target_i = tgt;
      #2;
   endtask

   task automatic chk_main(input string tag, input logic [5:0] st, input logic fl,
                           input logic npv, input logic [31:0] npc, input logic dr);
      check_val({tag, ".stall"}, {26'd0, stall}, {26'd0, st});
      check_val({tag, ".flush"}, {31'd0, flush_o}, {31'd0, fl});
      check_val({tag, ".npv"},   {31'd0, new_pc_valid_o}, {31'd0, npv});
      if (npv) check_val({tag, ".npc"}, new_pc_o, npc);
      check_val({tag, ".drain"}, {31'd0, drain_o}, {31'd0, dr});
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      cyc(); cyc();
      #2;
      chk_main("reset", 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
      check_val("reset.npc", new_pc_o, 32'h0);
      check_val("reset.hang", {31'd0, hang_o}, 32'd0);
      check_val("reset.scyc", stall_cycles_o, 32'd0);
      check_val("reset.fcnt", flush_cnt_o, 32'd0);

      cyc(); rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      // Priority
      cyc(); drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      chk_main("prio_mem", 6'b011111, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(); drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_main("prio_id", 6'b000111, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_main("prio_none", 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);

      // Branch, no fetch in flight
      cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
      chk_main("br_nofetch", 6'b000000, 1'b1, 1'b1, 32'h100, 1'b0);
      cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_main("br_after", 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);

      // Branch during fetch
      cyc(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
      chk_main("drn0", 6'b000011, 1'b1, 1'b0, 32'h0, 1'b1);
      cyc(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_main("drn1", 6'b000011, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc(); drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0999);
      chk_main("drn2_ign", 6'b000011, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_main("drn3", 6'b000011, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_main("drn_done", 6'b000011, 1'b0, 1'b1, 32'h200, 1'b1);
      cyc(); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_main("drn_run", 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);

      // Branch blocked by EX for 5 cycles, accepted in the 6th
      for (int i = 0; i < 5; i++) begin
         cyc(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300);
         chk_main("blk_ex", 6'b001111, 1'b0, 1'b0, 32'h0, 1'b0);
      end
      cyc(); drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
      chk_main("blk_acc", 6'b000000, 1'b1, 1'b1, 32'h300, 1'b0);

      // Reset mid-DRAIN
      cyc(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400);
      chk_main("rd_acc", 6'b000011, 1'b1, 1'b0, 32'h0, 1'b1);
      cyc(); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_main("rd_drain", 6'b000011, 1'b0, 1'b0, 32'h0, 1'b1);
`ifdef PIPE_CTRL_PERF_EN
      check_val("perf.scyc", stall_cycles_o, 32'd13);
      check_val("perf.fcnt", flush_cnt_o, 32'd4);
`else
      check_val("perf.scyc_off", stall_cycles_o, 32'd0);
      check_val("perf.fcnt_off", flush_cnt_o, 32'd0);
`endif
      rst = 1'b0;
      #1;
      chk_main("rd_inrst", 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
      check_val("rd_inrst.hang", {31'd0, hang_o}, 32'd0);
      cyc(); rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_main("rd_lost", 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);

      // Watchdog, timeout 8
      cyc(); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 1; i <= 7; i++) begin
         cyc();
      end
      #2;
      check_val("wdog_7", {31'd0, hang_o}, 32'd0);
      cyc(); #2;
      check_val("wdog_8", {31'd0, hang_o}, 32'd1);
`ifdef PIPE_CTRL_PERF_EN
      check_val("wdog_scyc", stall_cycles_o, 32'd8);
`endif
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      cyc(); #2;
      check_val("wdog_sticky", {31'd0, hang_o}, 32'd1);
      chk_main("wdog_rel", 6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
      check_val("wdog_scyc_hold", stall_cycles_o, 32'd8);
`endif
      cyc(); cyc(); #2;
      check_val("wdog_sticky2", {31'd0, hang_o}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
